// File: rtl/memory_map_multi_if.sv
// MMIO bus between the host-facing shim and the AFU memory map.
// The host drives reads and writes; the memory map answers with registered read data.
interface mmio_if;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [63:0] wr_data;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic [63:0] rd_data;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  rd_data
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data
   );

   modport user (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data
   );
endinterface

// File: rtl/memory_map_multi.sv
// Multi-channel AFU memory map: NUM_CH independent channels, each with
// configuration registers, a one-cycle go pulse, sticky done/busy/err status
// (write-1-to-clear) and a saturating go-to-done cycle counter. A global
// window adds a read-only ID register and a broadcast-go register.
module memory_map_multi #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned SIZE_WIDTH = 32,
   parameter int unsigned NUM_CH     = 4,
   parameter logic [15:0] BASE_ADDR  = 16'h0050,
   parameter logic [15:0] CH_STRIDE  = 16'h0010,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   mmio_if.user                             mmio,
   output logic [NUM_CH*ADDR_WIDTH-1:0]     rd_addr,
   output logic [NUM_CH*ADDR_WIDTH-1:0]     wr_addr,
   output logic [NUM_CH*SIZE_WIDTH-1:0]     num_samples,
   output logic [NUM_CH*SIZE_WIDTH-1:0]     collect_cycles,
   output logic [NUM_CH-1:0]                go,
   input  logic [NUM_CH-1:0]                done
);

   // Register offsets within a channel window.
   localparam logic [15:0] OFF_GO   = 16'h0000;
   localparam logic [15:0] OFF_RD   = 16'h0002;
   localparam logic [15:0] OFF_WR   = 16'h0004;
   localparam logic [15:0] OFF_NUM  = 16'h0006;
   localparam logic [15:0] OFF_COLL = 16'h0008;
   localparam logic [15:0] OFF_ST   = 16'h000A;
   localparam logic [15:0] OFF_CNT  = 16'h000C;

   // Global window sits directly after the last channel.
   localparam logic [15:0] GLB_ADDR  = BASE_ADDR + 16'(NUM_CH) * CH_STRIDE;
   localparam logic [15:0] ID_ADDR   = GLB_ADDR + 16'h0000;
   localparam logic [15:0] BCST_ADDR = GLB_ADDR + 16'h0002;
   localparam logic [63:0] ID_VALUE  = {48'h0, 8'h02, 8'(NUM_CH)};

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_WIDTH'(1);
   endfunction

   logic        bcast_wr;
   logic [63:0] ch_rd_val [NUM_CH];
   logic [63:0] rd_next;

   assign bcast_wr = mmio.wr_en && (mmio.wr_addr == BCST_ADDR);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [15:0] CB = BASE_ADDR + 16'(c) * CH_STRIDE;

      state_t                  state;
      logic [ADDR_WIDTH-1:0]   rd_addr_q;
      logic [ADDR_WIDTH-1:0]   wr_addr_q;
      logic [SIZE_WIDTH-1:0]   num_q;
      logic [SIZE_WIDTH-1:0]   coll_q;
      logic                    done_q;
      logic                    err_q;
      logic                    go_q;
      logic [CNT_WIDTH-1:0]    cnt_q;

      logic                    sel_go;
      logic                    go_req;
      logic                    cfg_wr;
      logic                    st_wr;
      logic [63:0]             rd_val;

      assign sel_go = mmio.wr_en && (mmio.wr_addr == CB + OFF_GO);
      assign go_req = (sel_go && mmio.wr_data[0]) || (bcast_wr && mmio.wr_data[c]);
      assign cfg_wr = mmio.wr_en && ((mmio.wr_addr == CB + OFF_RD)  ||
                                     (mmio.wr_addr == CB + OFF_WR)  ||
                                     (mmio.wr_addr == CB + OFF_NUM) ||
                                     (mmio.wr_addr == CB + OFF_COLL));
      assign st_wr  = mmio.wr_en && (mmio.wr_addr == CB + OFF_ST);

      // Channel FSM, config registers, sticky status and cycle counter.
      // Status clears are applied before the set events so a set in the
      // same cycle overrides the write-1-to-clear.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state     <= IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            num_q     <= '0;
            coll_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            go_q      <= 1'b0;
            cnt_q     <= '0;
         end else begin
            go_q <= 1'b0;

            if (st_wr) begin
               if (mmio.wr_data[0]) begin
                  done_q <= 1'b0;
               end
               if (mmio.wr_data[2]) begin
                  err_q <= 1'b0;
               end
            end

            case (state)
               IDLE: begin
                  // A done seen while idle is ignored, so a held level cannot retrigger.
                  if (go_req) begin
                     go_q   <= 1'b1;
                     state  <= BUSY;
                     done_q <= 1'b0;
                     cnt_q  <= '0;
                  end
                  if (cfg_wr) begin
                     if (mmio.wr_addr == CB + OFF_RD) begin
                        rd_addr_q <= mmio.wr_data[ADDR_WIDTH-1:0];
                     end
                     if (mmio.wr_addr == CB + OFF_WR) begin
                        wr_addr_q <= mmio.wr_data[ADDR_WIDTH-1:0];
                     end
                     if (mmio.wr_addr == CB + OFF_NUM) begin
                        num_q <= mmio.wr_data[SIZE_WIDTH-1:0];
                     end
                     if (mmio.wr_addr == CB + OFF_COLL) begin
                        coll_q <= mmio.wr_data[SIZE_WIDTH-1:0];
                     end
                  end
               end
               BUSY: begin
                  // The done edge itself does not count, so the count equals the
                  // distance in cycles from the go pulse to the done cycle.
                  if (done[c]) begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end else begin
                     cnt_q <= sat_inc(cnt_q);
                  end
                  // Config is frozen during a run; restarts are rejected.
                  if (go_req || cfg_wr) begin
                     err_q <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end

      // Per-channel read value; zero when the address is not in this window.
      always_comb begin
         rd_val = '0;
         if (mmio.rd_addr == CB + OFF_RD) begin
            rd_val = 64'(rd_addr_q);
         end else if (mmio.rd_addr == CB + OFF_WR) begin
            rd_val = 64'(wr_addr_q);
         end else if (mmio.rd_addr == CB + OFF_NUM) begin
            rd_val = 64'(num_q);
         end else if (mmio.rd_addr == CB + OFF_COLL) begin
            rd_val = 64'(coll_q);
         end else if (mmio.rd_addr == CB + OFF_ST) begin
            rd_val = {61'h0, err_q, (state == BUSY), done_q};
         end else if (mmio.rd_addr == CB + OFF_CNT) begin
            rd_val = 64'(cnt_q);
         end
      end

      assign ch_rd_val[c] = rd_val;

      assign rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH]        = rd_addr_q;
      assign wr_addr[c*ADDR_WIDTH +: ADDR_WIDTH]        = wr_addr_q;
      assign num_samples[c*SIZE_WIDTH +: SIZE_WIDTH]    = num_q;
      assign collect_cycles[c*SIZE_WIDTH +: SIZE_WIDTH] = coll_q;
      assign go[c]                                      = go_q;
   end

   // Read mux: at most one channel window hits, so the values are OR-merged.
   always_comb begin
      rd_next = '0;
      if (mmio.rd_addr == ID_ADDR) begin
         rd_next = ID_VALUE;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         rd_next = rd_next | ch_rd_val[c];
      end
   end

   // Registered read data; holds its value between reads. Sampling the
   // pre-edge register state gives the pre-write value on a same-cycle write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mmio.rd_data <= '0;
      end else if (mmio.rd_en) begin
         mmio.rd_data <= rd_next;
      end
   end

endmodule

// File: doc/memory_map_multi.md
Name: memory_map_multi

Overview:
- Parametrised successor to the single-channel AFU memory map: NUM_CH independent ring-oscillator/DMA channels behind one MMIO window.
- Per channel: config registers, a go pulse, a sticky done/busy/error status with write-1-to-clear, and a go-to-done cycle counter.
- Adds a broadcast-go register so several channels start on the same clock, plus a read-only ID register.
- Sits between mmio_if and the channel cores inside the AFU.

Parameters:
ADDR_WIDTH, 64, width of rd_addr/wr_addr (virtual byte addresses)
SIZE_WIDTH, 32, width of num_samples/collect_cycles
NUM_CH, 4, channel count, legal 1..8
BASE_ADDR, 16'h0050, MMIO address of channel 0 register 0
CH_STRIDE, 16'h0010, address spacing between channels
CNT_WIDTH, 32, width of the per-channel cycle counter (<=64)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mmio  mmio_if.user  -  wr_en, wr_addr[15:0], wr_data[63:0], rd_en, rd_addr[15:0], rd_data[63:0]
rd_addr  out  NUM_CH*ADDR_WIDTH  per-channel read base, channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
wr_addr  out  NUM_CH*ADDR_WIDTH  per-channel write base
num_samples  out  NUM_CH*SIZE_WIDTH  per-channel cache-line count
collect_cycles  out  NUM_CH*SIZE_WIDTH  per-channel collection window
go  out  NUM_CH  one-cycle start pulse per channel
done  in  NUM_CH  completion from channel cores (pulse or level)

Behaviour:
- Reset: every output register, status bit, counter and mmio.rd_data = 0; all channels IDLE.
- Channel c base is Bc = BASE_ADDR + c*CH_STRIDE. Offsets:
  - +0: go (W)
  - +2: rd_addr (RW)
  - +4: wr_addr (RW)
  - +6: num_samples (RW)
  - +8: collect_cycles (RW)
  - +A: status (R: bit0 done, bit1 busy, bit2 err; W: write 1 to bits 0/2 clears them)
  - +C: cycle count (R)
- Global registers, G = BASE_ADDR + NUM_CH*CH_STRIDE:
  - G+0: ID (R): [7:0] = NUM_CH, [15:8] = 8'h02.
  - G+2: broadcast go (W): wr_data[NUM_CH-1:0] is a channel mask.
- Writes: narrower fields take the low bits of wr_data; writes to unmapped addresses are ignored.
- Per-channel FSM has two states, IDLE and BUSY.
  - A go request is a write to Bc+0 with wr_data[0]=1, or a broadcast-go write with mask bit c set.
  - IDLE + go request: go[c]=1 on the cycle after the write, for exactly one cycle. Same edge: enter BUSY, clear done, clear counter.
  - BUSY + go request: go suppressed, err set.
  - BUSY + done[c]=1: return to IDLE, set done, freeze counter.
  - IDLE + done[c]: ignored, so a level-held done does not retrigger.
  - Broadcast: every masked IDLE channel pulses go on the same cycle; masked BUSY channels set err.
- Config register writes (+2..+8) while the channel is BUSY are ignored and set err. Outputs stay stable during a run.
- Cycle counter increments each BUSY cycle starting the cycle after entry, saturates at all-ones, and holds its value in IDLE.
- Simultaneous events:
  - Go request and done in the same cycle while BUSY: done processed, go rejected, err set.
  - W1C and a set event on the same bit in the same cycle: set wins.
- Reads:
  - mmio.rd_data is registered, 1-cycle latency after rd_en, zero-extended to 64 bits.
  - Unmapped reads return 0; rd_data holds its value when rd_en=0.
  - Reading a register and writing it in the same cycle returns the pre-write value.
- Reset mid-run: immediate return to the reset state, no go emitted, pending done lost.

Test Plan:
- Reset, then read all NUM_CH=4 channel registers and ID -> all 0 except ID = 64'h0204; go = 4'b0000.
- Ch1: write rd_addr = 64'h1000_0000, num_samples = 512, then go -> go = 4'b0010 for exactly one cycle, status = 2 (busy). Readback returns the written values.
- Ch1 BUSY 100 cycles then done pulse -> status = 1, cycle count = 100. Done held high 20 more cycles -> count stays 100, no state change.
- Ch1 BUSY: write num_samples = 7 and go -> num_samples unchanged, no go pulse, status = 6 (busy, err). Write 5 to status after done -> status = 0.
- Broadcast mask 4'b1011 with ch3 BUSY -> go = 4'b0011 on a single cycle, ch3 err set, ch2 untouched.
- Assert rst while ch0 BUSY with counter at 50 -> all outputs 0 asynchronously; after release status = 0, count = 0, no spurious go.
